// File: rtl/instr_pkg.sv
// Shared instruction-slot definitions for the scheduler and the instruction decoder.
package instr_pkg;

  localparam int unsigned SLOT_W         = 32;
  localparam int unsigned SLOTS_PER_BEAT = 16;
  localparam int unsigned BEAT_W         = SLOT_W * SLOTS_PER_BEAT;

  localparam int unsigned BG_W   = 2;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned ROW_W  = 17;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_PRE = 3'd1;
  localparam logic [2:0] OP_ACT = 3'd2;
  localparam logic [2:0] OP_RD  = 3'd3;
  localparam logic [2:0] OP_WR  = 3'd4;

  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned BANK_LSB = 3;
  localparam int unsigned BG_LSB   = BANK_LSB + BANK_W;
  localparam int unsigned ADDR_LSB = BG_LSB + BG_W;

  // Pack one command into a slot; undefined opcodes become NOP, unused upper bits stay zero.
  function automatic logic [SLOT_W-1:0] encode_slot(
    input logic [2:0]        op,
    input logic [BG_W-1:0]   bg,
    input logic [BANK_W-1:0] bank,
    input logic [ROW_W-1:0]  addr
  );
    logic [SLOT_W-1:0] s;
    s = '0;
    case (op)
      OP_NOP, OP_PRE, OP_ACT, OP_RD, OP_WR: s[OP_LSB +: 3] = op;
      default:                              s[OP_LSB +: 3] = OP_NOP;
    endcase
    s[BANK_LSB +: BANK_W] = bank;
    s[BG_LSB +: BG_W]     = bg;
    s[ADDR_LSB +: ROW_W]  = addr;
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search begins one past ptr and wraps.
// Ports: req (request vector), ptr (last winner), en (allow grant),
//        grant (one-hot, zero when !en), grant_idx (winner index, valid when |req).
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic        found;
  int unsigned idx;

  // First requester after ptr in circular order wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/instr_scheduler.sv
// Arbitrates DDR4 command requesters and packs commands into 512-bit AXI4-Stream beats
// (16 x 32-bit slots, slot 0 first), inserting per-command NOP gaps and padding
// partial beats on idle timeout or flush.
// Ports: clk, rst_n (async active-low); req_valid/req_ready per requester with packed
//        req_op/req_bg/req_bank/req_addr/req_gap fields; flush pulse;
//        M_AXIS_TDATA/TVALID/TREADY output stream; busy; beat_count (transfers, wraps).
module instr_scheduler
  import instr_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned BG_WIDTH      = 2,
  parameter int unsigned BANK_WIDTH    = 2,
  parameter int unsigned COL_WIDTH     = 10,
  parameter int unsigned ROW_WIDTH     = 17,
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3*NUM_REQ-1:0]          req_op,
  input  logic [BG_WIDTH*NUM_REQ-1:0]   req_bg,
  input  logic [BANK_WIDTH*NUM_REQ-1:0] req_bank,
  input  logic [ROW_WIDTH*NUM_REQ-1:0]  req_addr,
  input  logic [4*NUM_REQ-1:0]          req_gap,
  input  logic                          flush,
  output logic [BEAT_W-1:0]             M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic                          busy,
  output logic [31:0]                   beat_count
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W  = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [3:0]  LAST_SLOT = 4'(SLOTS_PER_BEAT - 1);

  // Field widths must match the shared slot layout.
  if (BG_WIDTH != BG_W || BANK_WIDTH != BANK_W || ROW_WIDTH != ROW_W ||
      COL_WIDTH > ROW_WIDTH || FLUSH_TIMEOUT < 1) begin : g_param_check
    $error("instr_scheduler: unsupported parameter set");
  end

  logic [3:0]        slot_idx, slot_nxt;
  logic [3:0]        gap_cnt, gap_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic              flush_pend, pend_nxt;
  logic [BEAT_W-1:0] asm_q, asm_nxt, asm_wr;
  logic [BEAT_W-1:0] out_data, out_data_nxt;
  logic              out_valid, out_valid_nxt;
  logic [31:0]       beat_cnt_nxt;
  logic              busy_nxt;

  logic              can_commit, slot_write_ok, flush_req;
  logic              arb_en, do_write;
  logic [SLOT_W-1:0] slot_val, win_slot;
  logic [IDX_W-1:0]  gnt_idx;
  logic [2:0]        win_op;
  logic [3:0]        win_gap;
  logic [BG_WIDTH-1:0]   win_bg;
  logic [BANK_WIDTH-1:0] win_bank;
  logic [ROW_WIDTH-1:0]  win_addr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (req_ready),
    .grant_idx (gnt_idx)
  );

  assign win_op   = req_op[gnt_idx*3 +: 3];
  assign win_gap  = req_gap[gnt_idx*4 +: 4];
  assign win_bg   = req_bg[gnt_idx*BG_WIDTH +: BG_WIDTH];
  assign win_bank = req_bank[gnt_idx*BANK_WIDTH +: BANK_WIDTH];
  assign win_addr = req_addr[gnt_idx*ROW_WIDTH +: ROW_WIDTH];
  assign win_slot = encode_slot(win_op, BG_W'(win_bg), BANK_W'(win_bank), ROW_W'(win_addr));

  assign can_commit    = !out_valid || M_AXIS_TREADY;
  assign slot_write_ok = (slot_idx != LAST_SLOT) || can_commit;
  // Flush only means anything with a partial beat; a pending one survives until committed.
  assign flush_req     = (slot_idx != 4'd0) &&
                         (flush_pend || flush || (timer == TMR_W'(FLUSH_TIMEOUT)));

  // Slot write / commit / handshake next-state.
  always_comb begin
    slot_nxt      = slot_idx;
    gap_nxt       = gap_cnt;
    rr_nxt        = rr_ptr;
    asm_nxt       = asm_q;
    asm_wr        = asm_q;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    beat_cnt_nxt  = beat_count;
    arb_en        = 1'b0;
    do_write      = 1'b0;
    slot_val      = '0;
    pend_nxt      = flush_req;
    timer_nxt     = '0;

    if (slot_idx != 4'd0 && gap_cnt == 4'd0 && !(|req_valid)) timer_nxt = timer + 1'b1;

    if (out_valid && M_AXIS_TREADY) begin
      out_valid_nxt = 1'b0;
      beat_cnt_nxt  = beat_count + 32'd1;
    end

    // Gap NOPs first; a flush seen meanwhile stays pending through pend_nxt.
    if (gap_cnt != 4'd0) begin
      if (slot_write_ok) begin
        do_write = 1'b1;
        gap_nxt  = gap_cnt - 4'd1;
      end
    end else if (flush_req) begin
      timer_nxt = '0;
      if (can_commit) begin
        out_data_nxt  = asm_q;
        out_valid_nxt = 1'b1;
        asm_nxt       = '0;
        slot_nxt      = '0;
        pend_nxt      = 1'b0;
      end
    end else if ((|req_valid) && slot_write_ok && rst_n) begin
      arb_en   = 1'b1;
      do_write = 1'b1;
      slot_val = win_slot;
      gap_nxt  = win_gap;
      rr_nxt   = gnt_idx;
    end

    if (do_write) begin
      asm_wr[int'(slot_idx)*SLOT_W +: SLOT_W] = slot_val;
      if (slot_idx == LAST_SLOT) begin
        out_data_nxt  = asm_wr;
        out_valid_nxt = 1'b1;
        asm_nxt       = '0;
        slot_nxt      = '0;
      end else begin
        asm_nxt  = asm_wr;
        slot_nxt = slot_idx + 4'd1;
      end
    end

    busy_nxt = (slot_nxt != 4'd0) || out_valid_nxt || (gap_nxt != 4'd0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_idx   <= '0;
      gap_cnt    <= '0;
      rr_ptr     <= '0;
      timer      <= '0;
      flush_pend <= 1'b0;
      asm_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      beat_count <= '0;
      busy       <= 1'b0;
    end else begin
      slot_idx   <= slot_nxt;
      gap_cnt    <= gap_nxt;
      rr_ptr     <= rr_nxt;
      timer      <= timer_nxt;
      flush_pend <= pend_nxt;
      asm_q      <= asm_nxt;
      out_data   <= out_data_nxt;
      out_valid  <= out_valid_nxt;
      beat_count <= beat_cnt_nxt;
      busy       <= busy_nxt;
    end
  end

  assign M_AXIS_TDATA  = out_data;
  assign M_AXIS_TVALID = out_valid;

endmodule

// File: tb/tb_instr_scheduler.sv
// Scoreboard bench for instr_scheduler: directed command sequences push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_instr_scheduler;
  import instr_pkg::*;

  localparam int unsigned NR = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [3*NR-1:0] req_op;
  logic [2*NR-1:0] req_bg;
  logic [2*NR-1:0] req_bank;
  logic [17*NR-1:0] req_addr;
  logic [4*NR-1:0] req_gap;
  logic            flush;
  logic [511:0]    M_AXIS_TDATA;
  logic            M_AXIS_TVALID;
  logic            M_AXIS_TREADY;
  logic            busy;
  logic [31:0]     beat_count;

  int checks = 0;
  int errors = 0;
  logic [511:0] exp_q[$];

  // Hand-computed slot encodings.
  localparam logic [31:0] ENC_A   = 32'h00D5_E6B2; // ACT bg1 bank2 addr 0x1ABCD
  localparam logic [31:0] ENC_B   = 32'h0001_FFCC; // WR  bg2 bank1 addr 0x3FF
  localparam logic [31:0] ENC_RD  = 32'h0000_0903; // RD  bg0 bank0 addr 0x12
  localparam logic [31:0] ENC_PRE = 32'h0000_0079; // PRE bg3 bank3 addr 0

  instr_scheduler #(.NUM_REQ(NR), .BG_WIDTH(2), .BANK_WIDTH(2), .COL_WIDTH(10),
                    .ROW_WIDTH(17), .FLUSH_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_bg(req_bg), .req_bank(req_bank), .req_addr(req_addr),
    .req_gap(req_gap), .flush(flush), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .busy(busy), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && M_AXIS_TVALID && M_AXIS_TREADY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=%0h required=none", M_AXIS_TDATA);
      end else begin
        chk("beat", M_AXIS_TDATA, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int r, input logic [2:0] op, input logic [1:0] bg,
                         input logic [1:0] bank, input logic [16:0] addr, input logic [3:0] gap);
    req_op[3*r +: 3]    = op;
    req_bg[2*r +: 2]    = bg;
    req_bank[2*r +: 2]  = bank;
    req_addr[17*r +: 17] = addr;
    req_gap[4*r +: 4]   = gap;
  endtask

  // Present one command and hold it until granted; returns cycles spent waiting.
  task automatic issue(input int r, input logic [2:0] op, input logic [1:0] bg,
                       input logic [1:0] bank, input logic [16:0] addr, input logic [3:0] gap,
                       output int waited);
    bit got;
    set_req(r, op, bg, bank, addr, gap);
    req_valid[r] = 1'b1;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual=no_grant required=grant r=%0d", r);
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 beats left", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [511:0] b1, b2;
    int w, n;
    req_valid = '0; req_op = '0; req_bg = '0; req_bank = '0; req_addr = '0; req_gap = '0;
    flush = 1'b0;
    M_AXIS_TREADY = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 512'(M_AXIS_TVALID), 512'(0));
    chk("rst_tdata", M_AXIS_TDATA, 512'(0));
    chk("rst_ready", 512'(req_ready), 512'(0));
    chk("rst_beat_count", 512'(beat_count), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: 16 identical ACTs from R0 make one full beat
    b1 = '0;
    for (int k = 0; k < 16; k++) b1[32*k +: 32] = ENC_A;
    exp_q.push_back(b1);
    for (int k = 0; k < 16; k++) issue(0, OP_ACT, 2'd1, 2'd2, 17'h1ABCD, 4'd0, w);
    drain();
    chk("t1_beat_count", 512'(beat_count), 512'(1));

    // T2: both requesters always valid, grants alternate starting with R1
    b1 = '0;
    for (int k = 0; k < 16; k++) b1[32*k +: 32] = (k % 2 == 0) ? ENC_B : ENC_A;
    exp_q.push_back(b1);
    set_req(0, OP_ACT, 2'd1, 2'd2, 17'h1ABCD, 4'd0);
    set_req(1, OP_WR, 2'd2, 2'd1, 17'h003FF, 4'd0);
    req_valid = 2'b11;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("t2_grant", 512'(req_ready), (k % 2 == 0) ? 512'(2'b10) : 512'(2'b01));
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // T3: RD with gap=3 at slot 14 puts NOPs in slots 15, 0, 1
    b1 = '0;
    for (int k = 0; k < 14; k++) b1[32*k +: 32] = ENC_A;
    b1[32*14 +: 32] = ENC_RD;
    b2 = '0;
    for (int k = 2; k < 16; k++) b2[32*k +: 32] = ENC_PRE;
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    for (int k = 0; k < 14; k++) issue(0, OP_ACT, 2'd1, 2'd2, 17'h1ABCD, 4'd0, w);
    issue(0, OP_RD, 2'd0, 2'd0, 17'h00012, 4'd3, w);
    issue(0, OP_PRE, 2'd3, 2'd3, 17'h0, 4'd0, w);
    chk("t3_gap_wait", 512'(w), 512'(3));
    for (int k = 0; k < 13; k++) issue(0, OP_PRE, 2'd3, 2'd3, 17'h0, 4'd0, w);
    drain();

    // T4: 5 commands then idle; timeout pads the beat
    b1 = '0;
    for (int k = 0; k < 5; k++) b1[32*k +: 32] = 32'h2 + ((k + 1) << 7);
    exp_q.push_back(b1);
    for (int k = 0; k < 5; k++) issue(1, OP_ACT, 2'd0, 2'd0, 17'(k + 1), 4'd0, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!M_AXIS_TVALID && n < 100);
    chk("t4_timeout_in_window", 512'(n >= 17 && n <= 19), 512'(1));
    drain();

    // T5: TREADY low across two beats; second stalls at slot 15
    b1 = '0;
    b2 = '0;
    for (int k = 0; k < 16; k++) begin
      b1[32*k +: 32] = 32'h1C + (k << 7);
      b2[32*k +: 32] = 32'h1C + ((k + 16) << 7);
    end
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    M_AXIS_TREADY = 1'b0;
    for (int k = 0; k < 31; k++) issue(1, OP_WR, 2'd0, 2'd3, 17'(k), 4'd0, w);
    set_req(1, OP_WR, 2'd0, 2'd3, 17'd31, 4'd0);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_stall_ready", 512'(req_ready), 512'(0));
      chk("t5_tdata_stable", M_AXIS_TDATA, b1);
    end
    chk("t5_busy", 512'(busy), 512'(1));
    @(posedge clk); #1;
    M_AXIS_TREADY = 1'b1;
    @(negedge clk);
    chk("t5_release_grant", 512'(req_ready), 512'(2'b10));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("t5_tvalid_kept", 512'(M_AXIS_TVALID), 512'(1));
    drain();

    // T6: reset with a beat held and a partial beat at slot 7
    M_AXIS_TREADY = 1'b0;
    for (int k = 0; k < 23; k++) issue(0, OP_ACT, 2'd1, 2'd2, 17'h1ABCD, 4'd0, w);
    chk("t6_pre_beat_count", 512'(beat_count), 512'(7));
    chk("t6_pre_tvalid", 512'(M_AXIS_TVALID), 512'(1));
    req_valid[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", 512'(M_AXIS_TVALID), 512'(0));
    chk("t6_rst_tdata", M_AXIS_TDATA, 512'(0));
    chk("t6_rst_busy", 512'(busy), 512'(0));
    chk("t6_rst_beat_count", 512'(beat_count), 512'(0));
    chk("t6_rst_ready", 512'(req_ready), 512'(0));
    @(posedge clk); #1;
    req_valid = '0;
    M_AXIS_TREADY = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_idle_flush_ignored", 512'(M_AXIS_TVALID), 512'(0));
    end
    @(posedge clk); #1;
    b1 = '0;
    b1[32*1 +: 32] = ENC_A;
    exp_q.push_back(b1);
    issue(0, 3'd6, 2'd0, 2'd0, 17'h0, 4'd0, w);
    issue(0, OP_ACT, 2'd1, 2'd2, 17'h1ABCD, 4'd0, w);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drain();
    chk("t6_beat_count", 512'(beat_count), 512'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
